lane_phase_scheduler: RTL and testbench



---
 rtl/lane_phase_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_lane_phase_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_phase_scheduler.sv
// Four-approach intersection phase scheduler.
// Grants green to one approach (two lanes) at a time based on queued demand.
// Supports day/night green lengths, latched pedestrian walk phases and
// emergency preemption. Every phase change passes through an all-red clearance.
module lane_phase_scheduler #(
  parameter int unsigned GREEN_DAY   = 8,
  parameter int unsigned GREEN_NIGHT = 4,
  parameter int unsigned CLEAR_TIME  = 2,
  parameter int unsigned PED_TIME    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hoursIn,
  input  logic        pedSignal,
  input  logic        emgSignal,
  input  logic [7:0]  emgLane,
  input  logic [63:0] laneCounts,
  output logic [7:0]  trafficLightOutput,
  output logic        walkOut,
  output logic [1:0]  trafficMode,
  output logic [7:0]  currentCount,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    StClear,
    StGreen,
    StPed,
    StEmg
  } state_e;

  // Timer loads are duration-1 so that a state lasts exactly its duration.
  localparam logic [7:0] ClearLoad      = 8'(CLEAR_TIME - 1);
  localparam logic [7:0] PedLoad        = 8'(PED_TIME - 1);
  localparam logic [7:0] GreenDayLoad   = 8'(GREEN_DAY - 1);
  localparam logic [7:0] GreenNightLoad = 8'(GREEN_NIGHT - 1);

  state_e      state_q;
  logic [7:0]  count_q;
  logic [7:0]  lights_q;
  logic        walk_q;
  logic        ped_pending_q;
  logic [1:0]  last_grant_q;
  logic [1:0]  phase_q;

  logic        night;
  logic        emg_active;
  logic [1:0]  emg_app;
  logic [8:0]  demand [4];
  logic [1:0]  sel_app;
  logic [8:0]  sel_demand;
  logic [1:0]  scan_idx;
  logic [7:0]  green_load;

  // Mode and emergency decode from the current inputs.
  always_comb begin
    night      = (hoursIn >= 5'd20) || (hoursIn < 5'd6);
    emg_active = emgSignal && (emgLane != 8'd0);
    green_load = night ? GreenNightLoad : GreenDayLoad;
    // Scan downwards so the lowest set lane is the last (winning) assignment.
    emg_app    = 2'd0;
    for (int i = 7; i >= 0; i--) begin
      if (emgLane[i]) emg_app = 2'(i >> 1);
    end
  end

  // Per-approach demand and round-robin max selection starting after lastGrant.
  always_comb begin
    for (int a = 0; a < 4; a++) begin
      demand[a] = {1'b0, laneCounts[16*a +: 8]} + {1'b0, laneCounts[16*a+8 +: 8]};
    end
    sel_app    = last_grant_q + 2'd1;
    sel_demand = demand[sel_app];
    scan_idx   = sel_app;
    // Strict compare keeps the earliest approach in round-robin order on ties.
    for (int k = 2; k <= 4; k++) begin
      scan_idx = last_grant_q + 2'(k);
      if (demand[scan_idx] > sel_demand) begin
        sel_app    = scan_idx;
        sel_demand = demand[scan_idx];
      end
    end
  end

  // Phase sequencing FSM with registered light, walk, timer and phase outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StClear;
      count_q       <= ClearLoad;
      lights_q      <= 8'd0;
      walk_q        <= 1'b0;
      ped_pending_q <= 1'b0;
      last_grant_q  <= 2'd3;
      phase_q       <= 2'd3;
    end else begin
      unique case (state_q)
        StClear: begin
          lights_q <= 8'd0;
          walk_q   <= 1'b0;
          if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
          end else if (emg_active) begin
            state_q      <= StEmg;
            count_q      <= 8'd0;
            lights_q     <= 8'h03 << {emg_app, 1'b0};
            phase_q      <= emg_app;
            last_grant_q <= emg_app;
          end else if (ped_pending_q) begin
            state_q       <= StPed;
            count_q       <= PedLoad;
            walk_q        <= 1'b1;
            ped_pending_q <= 1'b0;
          end else if ((sel_demand == 9'd0) && night) begin
            // Idle at night: hold all-red and re-evaluate every cycle.
            count_q <= 8'd0;
          end else begin
            state_q      <= StGreen;
            count_q      <= green_load;
            lights_q     <= 8'h03 << {sel_app, 1'b0};
            phase_q      <= sel_app;
            last_grant_q <= sel_app;
          end
        end
        StGreen: begin
          if (emg_active) begin
            // Emergency on the served approach freezes the timer; otherwise abort.
            if (emg_app != phase_q) begin
              state_q  <= StClear;
              count_q  <= ClearLoad;
              lights_q <= 8'd0;
            end
          end else if (count_q == 8'd0) begin
            state_q  <= StClear;
            count_q  <= ClearLoad;
            lights_q <= 8'd0;
          end else begin
            count_q <= count_q - 8'd1;
          end
        end
        StPed: begin
          if (emg_active || (count_q == 8'd0)) begin
            state_q <= StClear;
            count_q <= ClearLoad;
            walk_q  <= 1'b0;
          end else begin
            count_q <= count_q - 8'd1;
          end
        end
        StEmg: begin
          count_q <= 8'd0;
          if (emg_active) begin
            lights_q     <= 8'h03 << {emg_app, 1'b0};
            phase_q      <= emg_app;
            last_grant_q <= emg_app;
          end else begin
            state_q  <= StClear;
            count_q  <= ClearLoad;
            lights_q <= 8'd0;
          end
        end
        default: begin
          state_q  <= StClear;
          count_q  <= ClearLoad;
          lights_q <= 8'd0;
          walk_q   <= 1'b0;
        end
      endcase
      // A request on this edge is latched even if a pending one was just consumed.
      if (pedSignal) ped_pending_q <= 1'b1;
    end
  end

  // Mode reflects the current state and the live hour input.
  always_comb begin
    unique case (state_q)
      StEmg:   trafficMode = 2'b10;
      StPed:   trafficMode = 2'b11;
      default: trafficMode = night ? 2'b01 : 2'b00;
    endcase
  end

  assign trafficLightOutput = lights_q;
  assign walkOut            = walk_q;
  assign currentCount       = count_q;
  assign phase              = phase_q;

  // Safety: never green together with walk, and at most one approach green.
  assert property (@(posedge clk) !(walk_q && (lights_q != 8'd0)));
  assert property (@(posedge clk) lights_q inside {8'h00, 8'h03, 8'h0C, 8'h30, 8'hC0});

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Bench for lane_phase_scheduler: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural reference model.
module tb_lane_phase_scheduler;

  localparam int GD = 8;
  localparam int GN = 4;
  localparam int CT = 2;
  localparam int PT = 5;

  localparam int KClear = 0;
  localparam int KGreen = 1;
  localparam int KPed   = 2;
  localparam int KEmg   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hoursIn;
  logic        pedSignal;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic [63:0] laneCounts;
  logic [7:0]  trafficLightOutput;
  logic        walkOut;
  logic [1:0]  trafficMode;
  logic [7:0]  currentCount;
  logic [1:0]  phase;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_kind;
  int m_rem;
  int m_phase;
  int m_last;
  int m_pend;

  always #5 clk = ~clk;

  lane_phase_scheduler #(
    .GREEN_DAY  (GD),
    .GREEN_NIGHT(GN),
    .CLEAR_TIME (CT),
    .PED_TIME   (PT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .hoursIn           (hoursIn),
    .pedSignal         (pedSignal),
    .emgSignal         (emgSignal),
    .emgLane           (emgLane),
    .laneCounts        (laneCounts),
    .trafficLightOutput(trafficLightOutput),
    .walkOut           (walkOut),
    .trafficMode       (trafficMode),
    .currentCount      (currentCount),
    .phase             (phase)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_night(input int h);
    return (h >= 20) || (h < 6);
  endfunction

  function automatic int lowest_lane_app(input logic [7:0] lanes);
    for (int i = 0; i < 8; i++) begin
      if (lanes[i]) return i / 2;
    end
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int  d[4];
    int  maxd;
    int  pend_next;
    bit  emg;
    int  ea;
    bit  night;
    if (rst) begin
      m_kind  = KClear;
      m_rem   = CT - 1;
      m_phase = 3;
      m_last  = 3;
      m_pend  = 0;
      return;
    end
    for (int a = 0; a < 4; a++) begin
      d[a] = int'(laneCounts[16*a +: 8]) + int'(laneCounts[16*a+8 +: 8]);
    end
    maxd = 0;
    for (int a = 0; a < 4; a++) if (d[a] > maxd) maxd = d[a];
    emg       = emgSignal && (emgLane != 0);
    ea        = lowest_lane_app(emgLane);
    night     = is_night(int'(hoursIn));
    pend_next = m_pend;
    case (m_kind)
      KClear: begin
        if (m_rem > 0) begin
          m_rem--;
        end else if (emg) begin
          m_kind  = KEmg;
          m_rem   = 0;
          m_phase = ea;
          m_last  = ea;
        end else if (m_pend != 0) begin
          m_kind    = KPed;
          m_rem     = PT - 1;
          pend_next = 0;
        end else if (maxd == 0 && night) begin
          m_rem = 0;
        end else begin
          int pick;
          pick = -1;
          for (int k = 1; k <= 4; k++) begin
            if (pick < 0 && d[(m_last + k) % 4] == maxd) pick = (m_last + k) % 4;
          end
          m_kind  = KGreen;
          m_rem   = (night ? GN : GD) - 1;
          m_phase = pick;
          m_last  = pick;
        end
      end
      KGreen: begin
        if (emg) begin
          if (ea != m_phase) begin
            m_kind = KClear;
            m_rem  = CT - 1;
          end
        end else if (m_rem == 0) begin
          m_kind = KClear;
          m_rem  = CT - 1;
        end else begin
          m_rem--;
        end
      end
      KPed: begin
        if (emg || m_rem == 0) begin
          m_kind = KClear;
          m_rem  = CT - 1;
        end else begin
          m_rem--;
        end
      end
      default: begin
        if (emg) begin
          m_phase = ea;
          m_last  = ea;
        end else begin
          m_kind = KClear;
          m_rem  = CT - 1;
        end
      end
    endcase
    if (pedSignal) pend_next = 1;
    m_pend = pend_next;
  endtask

  task automatic compare_all();
    logic [7:0] exp_lights;
    logic [1:0] exp_mode;
    int         n_app;
    exp_lights = 8'h00;
    if (m_kind == KGreen || m_kind == KEmg) exp_lights = 8'h03 << (2 * m_phase);
    if (m_kind == KEmg) exp_mode = 2'b10;
    else if (m_kind == KPed) exp_mode = 2'b11;
    else exp_mode = is_night(int'(hoursIn)) ? 2'b01 : 2'b00;
    check_eq("lights", trafficLightOutput, exp_lights);
    check_eq("walk", walkOut, (m_kind == KPed) ? 1 : 0);
    check_eq("mode", trafficMode, exp_mode);
    check_eq("count", currentCount, m_rem);
    check_eq("phase", phase, m_phase);
    n_app = 0;
    for (int a = 0; a < 4; a++) if (trafficLightOutput[2*a +: 2] != 2'b00) n_app++;
    check_eq("invariant", ((n_app <= 1) && !(walkOut && n_app != 0)) ? 1 : 0, 1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int walk_cnt;

  initial begin
    rst        = 1'b1;
    hoursIn    = 5'd12;
    pedSignal  = 1'b0;
    emgSignal  = 1'b0;
    emgLane    = 8'd0;
    laneCounts = 64'd0;
    m_kind = KClear; m_rem = CT - 1; m_phase = 3; m_last = 3; m_pend = 0;

    // Day, only s1 queued: clearance, then 8-cycle green on S, then clearance.
    laneCounts[47:40] = 8'h7F;
    do_reset();
    check_eq("s1_rst_count", currentCount, 1);
    check_eq("s1_rst_phase", phase, 3);
    tick();
    tick();
    check_eq("s1_green_lights", trafficLightOutput, 8'h30);
    check_eq("s1_green_phase", phase, 2);
    repeat (8) tick();
    check_eq("s1_clear_lights", trafficLightOutput, 8'h00);
    check_eq("s1_clear_count", currentCount, 1);

    // Largest demand wins: W over N.
    laneCounts        = 64'd0;
    laneCounts[63:56] = 8'h30;
    laneCounts[7:0]   = 8'h0F;
    do_reset();
    tick();
    tick();
    check_eq("s2_west_lights", trafficLightOutput, 8'hC0);

    // Tie N=E=5 after reset (lastGrant=3): N first.
    laneCounts        = 64'd0;
    laneCounts[7:0]   = 8'd5;
    laneCounts[23:16] = 8'd5;
    do_reset();
    tick();
    tick();
    check_eq("s2_tie_phase", phase, 0);
    check_eq("s2_tie_lights", trafficLightOutput, 8'h03);

    // One-cycle pedestrian pulse during green is served exactly once.
    pedSignal = 1'b1;
    tick();
    pedSignal = 1'b0;
    walk_cnt  = 0;
    repeat (40) begin
      tick();
      if (walkOut) walk_cnt++;
    end
    check_eq("s3_walk_cycles", walk_cnt, PT);

    // Emergency on E while N is green: abort, clear, hold EMG.
    laneCounts        = 64'd0;
    laneCounts[15:8]  = 8'd9;
    do_reset();
    tick();
    tick();
    emgSignal = 1'b1;
    emgLane   = 8'b0000_1000;
    tick();
    check_eq("s4_abort_lights", trafficLightOutput, 8'h00);
    repeat (41) tick();
    check_eq("s4_emg_lights", trafficLightOutput, 8'h0C);
    check_eq("s4_emg_mode", trafficMode, 2'b10);
    check_eq("s4_emg_count", currentCount, 0);
    emgSignal = 1'b0;
    emgLane   = 8'd0;
    tick();
    check_eq("s4_release_lights", trafficLightOutput, 8'h00);
    check_eq("s4_release_count", currentCount, CT - 1);

    // Emergency on the green approach freezes the timer.
    do_reset();
    repeat (4) tick();
    check_eq("s5_pre_count", currentCount, 5);
    emgSignal = 1'b1;
    emgLane   = 8'b0000_0001;
    repeat (6) tick();
    check_eq("s5_frozen_count", currentCount, 5);
    check_eq("s5_frozen_lights", trafficLightOutput, 8'h03);
    emgSignal = 1'b0;
    emgLane   = 8'd0;
    tick();
    check_eq("s5_resume_count", currentCount, 4);

    // Night with no demand idles in clearance; then a short night green; then reset.
    hoursIn    = 5'd22;
    laneCounts = 64'd0;
    do_reset();
    repeat (5) tick();
    check_eq("s6_idle_mode", trafficMode, 2'b01);
    check_eq("s6_idle_count", currentCount, 0);
    check_eq("s6_idle_lights", trafficLightOutput, 8'h00);
    laneCounts[31:24] = 8'd3;
    tick();
    check_eq("s6_night_lights", trafficLightOutput, 8'h0C);
    check_eq("s6_night_count", currentCount, GN - 1);
    tick();
    do_reset();
    check_eq("s6_rst_lights", trafficLightOutput, 8'h00);
    check_eq("s6_rst_count", currentCount, CT - 1);
    check_eq("s6_rst_phase", phase, 3);

    // Randomized traffic, pedestrians, emergencies and occasional resets.
    repeat (4000) begin
      if ($urandom_range(0, 7) == 0) hoursIn = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) begin
        for (int l = 0; l < 8; l++) begin
          case ($urandom_range(0, 3))
            0, 1:    laneCounts[8*l +: 8] = 8'd0;
            2:       laneCounts[8*l +: 8] = 8'($urandom_range(0, 3));
            default: laneCounts[8*l +: 8] = 8'($urandom);
          endcase
        end
      end
      pedSignal = ($urandom_range(0, 24) == 0);
      if (emgSignal) begin
        if ($urandom_range(0, 29) == 0) emgSignal = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        emgSignal = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       emgLane = 8'd0;
          1, 2:    emgLane = 8'd1 << $urandom_range(0, 7);
          default: emgLane = 8'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
